// File: rtl/delta_pkg.sv
// Shared constants and state encoding for the delta decode path.
package delta_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dd_state_t;

endpackage

// File: rtl/delta_decoder_fifo.sv
// Synchronous DEPTH-entry FIFO; head_data holds the last popped value while empty.
module delta_decoder_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] last_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        last_q   <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/delta_decoder.sv
// Integrates a stream of modulo-2^WIDTH deltas back into absolute samples.
module delta_decoder #(
  parameter int unsigned WIDTH = delta_pkg::SAMPLE_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = delta_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  input  logic             io_in_first,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [CNT_W-1:0] io_count,
  output logic             io_err
);

  import delta_pkg::*;

  dd_state_t        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] head_data;
  logic             in_fire, out_fire;

  // Outputs are forced to their reset values while reset is held.
  assign io_in_ready  = !reset && !fifo_full;
  assign io_out_valid = !reset && !fifo_empty;
  assign io_out_bits  = reset ? '0 : head_data;
  assign io_count     = reset ? '0 : cnt_q;
  assign io_err       = reset ? 1'b0 : err_q;

  assign in_fire  = io_in_valid && io_in_ready;
  assign out_fire = io_out_valid && io_out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (in_fire) begin
      if (io_in_first || (state_q == IDLE)) begin
        // A delta with no preceding seed is taken relative to zero.
        acc_d   = io_in_bits;
        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = RUN;
        if (!io_in_first) begin
          err_d = 1'b1;
        end
      end else begin
        acc_d = acc_q + io_in_bits;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  delta_decoder_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_fire),
    .push_data(acc_d),
    .pop      (out_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_data(head_data)
  );

endmodule

// File: tb/tb_delta_decoder.sv
// Directed bench for delta_decoder with hand-computed expected samples.
module tb_delta_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_bits;
  logic        io_in_first;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_bits;
  logic [15:0] io_count;
  logic        io_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  delta_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_bits  (io_in_bits),
    .io_in_first (io_in_first),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits (io_out_bits),
    .io_count    (io_count),
    .io_err      (io_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample, wait (bounded) for acceptance, leave time at edge+1.
  task automatic send(input logic first, input logic [15:0] bits);
    int n;
    io_in_valid = 1'b1;
    io_in_first = first;
    io_in_bits  = bits;
    #1;
    n = 0;
    while (!io_in_ready && n < 20) begin
      step();
      n++;
    end
    if (!io_in_ready) check("accept_timeout", 32'd0, 32'd1);
    step();
    io_in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic first, input logic [15:0] bits,
                          input logic [15:0] exp);
    send(first, bits);
    check({tag, "_valid"}, {31'd0, io_out_valid}, 32'd1);
    check({tag, "_bits"}, {16'd0, io_out_bits}, {16'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_in_first  = 1'b0;
    io_out_ready = 1'b0;
    step();
    check("rst_in_ready", {31'd0, io_in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_valid", {31'd0, io_out_valid}, 32'd0);
    check("post_rst_bits", {16'd0, io_out_bits}, 32'd0);
    check("post_rst_count", {16'd0, io_count}, 32'd0);
    check("post_rst_err", {31'd0, io_err}, 32'd0);
    check("post_rst_ready", {31'd0, io_in_ready}, 32'd1);

    // Basic integration
    io_out_ready = 1'b1;
    send_chk("b0", 1'b1, 16'h1000, 16'h1000);
    send_chk("b1", 1'b0, 16'h0010, 16'h1010);
    send_chk("b2", 1'b0, 16'hFFF0, 16'h1000);
    send_chk("b3", 1'b0, 16'h0005, 16'h1005);
    check("b_count", {16'd0, io_count}, 32'd4);
    check("b_err", {31'd0, io_err}, 32'd0);
    step();
    check("b_drain", {31'd0, io_out_valid}, 32'd0);

    // Wrap-around
    send_chk("w0", 1'b1, 16'hFFFE, 16'hFFFE);
    send_chk("w1", 1'b0, 16'h0003, 16'h0001);
    send_chk("w2", 1'b0, 16'hFFFF, 16'h0000);
    check("w_count", {16'd0, io_count}, 32'd3);

    // Re-seed mid-stream
    send_chk("r0", 1'b1, 16'd100, 16'd100);
    send_chk("r1", 1'b0, 16'd10, 16'd110);
    check("r_count2", {16'd0, io_count}, 32'd2);
    send_chk("r2", 1'b1, 16'd7, 16'd7);
    check("r_count1", {16'd0, io_count}, 32'd1);
    send_chk("r3", 1'b0, 16'd1, 16'd8);
    check("r_count2b", {16'd0, io_count}, 32'd2);
    step();

    // Back-pressure with a 2-entry FIFO
    io_out_ready = 1'b0;
    send(1'b1, 16'd5);
    send(1'b0, 16'd1);
    check("bp_full_ready", {31'd0, io_in_ready}, 32'd0);
    io_in_valid = 1'b1;
    io_in_first = 1'b0;
    io_in_bits  = 16'd2;
    step();
    step();
    check("bp_held_ready", {31'd0, io_in_ready}, 32'd0);
    check("bp_stall_valid", {31'd0, io_out_valid}, 32'd1);
    check("bp_stall_bits", {16'd0, io_out_bits}, 32'd5);
    io_out_ready = 1'b1;
    step();
    check("bp_out6", {16'd0, io_out_bits}, 32'd6);
    check("bp_ready_again", {31'd0, io_in_ready}, 32'd1);
    step();
    io_in_valid = 1'b0;
    check("bp_out8_valid", {31'd0, io_out_valid}, 32'd1);
    check("bp_out8", {16'd0, io_out_bits}, 32'd8);
    step();
    check("bp_empty", {31'd0, io_out_valid}, 32'd0);
    check("bp_hold_bits", {16'd0, io_out_bits}, 32'd8);

    // Missing seed after reset
    do_reset();
    send_chk("m0", 1'b0, 16'h0042, 16'h0042);
    check("m_err", {31'd0, io_err}, 32'd1);
    send_chk("m1", 1'b1, 16'd9, 16'd9);
    check("m_err_sticky", {31'd0, io_err}, 32'd1);
    step();

    // Reset with entries queued
    io_out_ready = 1'b0;
    send(1'b1, 16'd20);
    send(1'b0, 16'd1);
    reset = 1'b1;
    #1;
    check("mr_ready_in_rst", {31'd0, io_in_ready}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mr_valid", {31'd0, io_out_valid}, 32'd0);
    check("mr_bits", {16'd0, io_out_bits}, 32'd0);
    check("mr_count", {16'd0, io_count}, 32'd0);
    check("mr_err", {31'd0, io_err}, 32'd0);
    io_out_ready = 1'b1;
    send_chk("mr0", 1'b0, 16'd3, 16'd3);
    check("mr_err_set", {31'd0, io_err}, 32'd1);
    check("mr_count1", {16'd0, io_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
